// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit : LW/SW data-memory stage with wait states and error flags |
// | Optional feature: define MEM_BYTE_EN for per-byte store enables (req_be).   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
`ifdef MEM_BYTE_EN
  input  logic [1:0]  req_be,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  c_ws    = 4'(WAIT_STATES);
  localparam logic [16:0] c_depth = 17'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_mem [DEPTH];

  logic        w_accept, w_access;
  logic        w_write, w_err, w_we;
  logic [15:0] w_addr, w_wdata, w_rdata;
  logic [1:0]  w_be;
  logic [AW-1:0] w_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_accept = 1'b1;
          // With no wait states the accept edge doubles as the access edge.
          if (c_ws == 4'd0) begin
            w_access = 1'b1;
            w_next   = S_RESP;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands come straight from the request port only on a zero-wait accept.
  assign w_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_idx   = w_addr[AW:1];
  assign w_err   = w_addr[0] | ({2'b00, w_addr[15:1]} >= c_depth);
  assign w_rdata = r_mem[w_idx];
  assign w_we    = w_access & w_write & ~w_err & ~reset;

`ifdef MEM_BYTE_EN
  logic [1:0] r_be;
  assign w_be = (r_state == S_IDLE) ? req_be : r_be;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_be <= 2'b00;
    else if (w_accept) r_be <= req_be;
  end
`else
  assign w_be = 2'b11;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_ws;
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        rsp_err   <= w_err;
        rsp_rdata <= (w_err | w_write) ? 16'h0000 : w_rdata;
      end
    end
  end

  // RAM has no reset; contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (w_we) begin
      if (w_be[0]) r_mem[w_idx][7:0]  <= w_wdata[7:0];
      if (w_be[1]) r_mem[w_idx][15:8] <= w_wdata[15:8];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench for mem_access_unit      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        v0, w0;
  logic [15:0] a0, d0;
  logic [1:0]  be0;
  logic        rdy0, val0, err0, busy0;
  logic [15:0] rd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(256), .WAIT_STATES(1)) dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_BYTE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  mem_access_unit #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(rst),
    .req_valid(v0), .req_ready(rdy0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0),
`ifdef MEM_BYTE_EN
    .req_be(be0),
`endif
    .rsp_valid(val0), .rsp_rdata(rd0), .rsp_err(err0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the WAIT_STATES=1 unit; lat is the cycle of rsp_valid counted from the accept cycle (0).
  task automatic op(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                    output logic [15:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    tick();
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  logic [8:0]  rdy_m, busy_m, val_m, rdy0_m;
  logic        saw;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b11;
    v0 = 1'b0; w0 = 1'b0; a0 = 16'h0004; d0 = '0; be0 = 2'b11;
    tick(); tick();
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_err",   32'(rsp_err),   32'd0);
    check("reset_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    tick();

    // Basic store then load
    op(1'b1, 16'h0004, 16'h1234, 2'b11, rd, er, lat);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(er), 32'd0);
    op(1'b0, 16'h0004, 16'h0000, 2'b11, rd, er, lat);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", 32'(rd), 32'h1234);
    check("lw_err", 32'(er), 32'd0);

    // Misaligned accesses
    op(1'b1, 16'h0002, 16'h7777, 2'b11, rd, er, lat);
    check("sw_rdata_zero", 32'(rd), 32'd0);
    op(1'b0, 16'h0003, 16'h0000, 2'b11, rd, er, lat);
    check("mis_lw_err", 32'(er), 32'd1);
    check("mis_lw_rdata", 32'(rd), 32'd0);
    check("mis_lw_lat", 32'(lat), 32'd2);
    op(1'b1, 16'h0003, 16'h9999, 2'b11, rd, er, lat);
    check("mis_sw_err", 32'(er), 32'd1);
    op(1'b0, 16'h0002, 16'h0000, 2'b11, rd, er, lat);
    check("mis_sw_nowrite", 32'(rd), 32'h7777);

    // Out-of-range store must not alias onto word 0
    op(1'b1, 16'h0000, 16'h0A0A, 2'b11, rd, er, lat);
    op(1'b1, 16'h0200, 16'hDEAD, 2'b11, rd, er, lat);
    check("oor_sw_err", 32'(er), 32'd1);
    op(1'b0, 16'h0000, 16'h0000, 2'b11, rd, er, lat);
    check("oor_nowrite", 32'(rd), 32'h0A0A);
    check("oor_reload_err", 32'(er), 32'd0);
    op(1'b0, 16'h01FE, 16'h0000, 2'b11, rd, er, lat);
    check("last_word_err", 32'(er), 32'd0);

    // req_valid held for back-to-back loads on both units
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0004;
    v0 = 1'b1;
    rdy_m = '0; busy_m = '0; val_m = '0; rdy0_m = '0;
    for (int c = 0; c < 9; c++) begin
      rdy_m[c] = req_ready; busy_m[c] = busy; val_m[c] = rsp_valid; rdy0_m[c] = rdy0;
      tick();
    end
    req_valid = 1'b0; v0 = 1'b0;
    check("b2b_ready",  32'(rdy_m),  32'b001001001);
    check("b2b_busy",   32'(busy_m), 32'b110110110);
    check("b2b_rspv",   32'(val_m),  32'b100100100);
    check("b2b_ready0", 32'(rdy0_m), 32'b101010101);
    tick(); tick();
    check("b2b_rdata", 32'(rsp_rdata), 32'h1234);

    // Reset during WAIT aborts a pending store
    op(1'b1, 16'h0010, 16'h5555, 2'b11, rd, er, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
    tick();
    check("wait_busy",  32'(busy),      32'd1);
    check("wait_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_busy",  32'(busy),      32'd0);
    tick(); tick();
    rst = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      saw |= rsp_valid;
      tick();
    end
    check("abort_no_rsp", 32'(saw), 32'd0);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    op(1'b0, 16'h0010, 16'h0000, 2'b11, rd, er, lat);
    check("abort_old_value", 32'(rd), 32'h5555);

`ifdef MEM_BYTE_EN
    op(1'b1, 16'h0006, 16'h1234, 2'b11, rd, er, lat);
    op(1'b1, 16'h0006, 16'hFFAB, 2'b01, rd, er, lat);
    op(1'b0, 16'h0006, 16'h0000, 2'b00, rd, er, lat);
    check("be01", 32'(rd), 32'h12AB);
    op(1'b1, 16'h0006, 16'hCD00, 2'b10, rd, er, lat);
    op(1'b0, 16'h0006, 16'h0000, 2'b01, rd, er, lat);
    check("be10", 32'(rd), 32'hCDAB);
    op(1'b1, 16'h0006, 16'h0000, 2'b00, rd, er, lat);
    check("be00_err", 32'(er), 32'd0);
    op(1'b0, 16'h0006, 16'h0000, 2'b11, rd, er, lat);
    check("be00", 32'(rd), 32'hCDAB);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
